// File: rtl/piccolo80_round_sched.sv
// Iterative Piccolo-80 round scheduler: whitening, state register and round sequencing
// around an external combinational single-round datapath.
module piccolo80_round_sched #(
  parameter int ROUNDS = 25,
  parameter int KSLOTS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] plaintext,
  input  logic [79:0] keyin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] ciphertext,
  output logic [63:0] rnd_din,
  output logic [4:0]  rnd_idx,
  output logic [2:0]  key_sel,
  output logic        rnd_last,
  input  logic [63:0] rnd_dout,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state, w_state_nx;
  logic        r_alive;
  logic [79:0] r_key;
  logic [63:0] r_st, r_ct;
  logic [4:0]  r_idx;
  logic [2:0]  r_ksel;
  logic        w_accept, w_last;
  logic [15:0] w_wk0, w_wk1, w_wk2, w_wk3;

  // XOR whitening keys into the two even 16-bit words (word 0 is the MSB word)
  function automatic logic [63:0] whiten(input logic [63:0] x, input logic [15:0] wa,
                                         input logic [15:0] wb);
    return {x[63:48] ^ wa, x[47:32], x[31:16] ^ wb, x[15:0]};
  endfunction

  // k0 = keyin[79:64] ... k4 = keyin[15:0]
  assign w_wk0 = {keyin[79:72], keyin[55:48]};
  assign w_wk1 = {keyin[63:56], keyin[71:64]};
  assign w_wk2 = {r_key[15:8],  r_key[23:16]};
  assign w_wk3 = {r_key[31:24], r_key[7:0]};

  assign w_last   = (r_state == S_RUN) && (r_idx == 5'(ROUNDS - 1));
  // r_alive keeps in_ready low while reset is held and until the first edge after release
  assign in_ready = r_alive && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nx = S_RUN;
      S_RUN:   if (w_last) w_state_nx = S_DONE;
      S_DONE:  if (out_ready) w_state_nx = w_accept ? S_RUN : S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_alive <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key  <= '0;
      r_st   <= '0;
      r_ct   <= '0;
      r_idx  <= '0;
      r_ksel <= '0;
    end else begin
      if (w_accept) begin
        r_key  <= keyin;
        r_st   <= whiten(plaintext, w_wk0, w_wk1);
        r_idx  <= '0;
        r_ksel <= '0;
      end else if (r_state == S_RUN && !w_last) begin
        r_st   <= rnd_dout;
        r_idx  <= r_idx + 5'd1;
        r_ksel <= (r_ksel == 3'(KSLOTS - 1)) ? 3'd0 : r_ksel + 3'd1;
      end
      // final round: index/slot/state freeze so they hold their last values outside RUN
      if (w_last) r_ct <= whiten(rnd_dout, w_wk2, w_wk3);
    end
  end

  assign rnd_din    = r_st;
  assign rnd_idx    = r_idx;
  assign key_sel    = r_ksel;
  assign rnd_last   = w_last;
  assign ciphertext = r_ct;
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state == S_RUN);

endmodule
